// File: rtl/rxfifo_pkg.sv
// Shared definitions for the UART-RX FIFO controller: register offsets, FSM states,
// and the bit positions in the STATUS register.
package rxfifo_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_e;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// FIFO write/read pointers with one extra wrap bit, plus the derived full, empty
// and occupancy values.
module fifo_ptr_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  output logic [ADDR_W:0]   wp,
  output logic [ADDR_W:0]   rp,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  // flush and pop never coincide: the APB side runs only one access at a time
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push)       wp <= wp + ONE;
      if (flush)      rp <= wp;
      else if (pop)   rp <= rp + ONE;
    end
  end

  assign empty = (wp == rp);
  assign full  = (wp[ADDR_W] != rp[ADDR_W]) && (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]);
  assign count = wp - rp;
endmodule

// File: rtl/apb_rxfifo_ctrl.sv
// APB slave and sequencer for the UART-RX -> block-RAM FIFO path. The DATA pop
// inserts wait states to cover the RAM's synchronous read latency.
module apb_rxfifo_ctrl
  import rxfifo_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W:0]   ram_wdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_re,
  input  logic [DATA_W:0]   ram_rdata,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [15:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq_nempty
);
  localparam logic [ADDR_W+1:0] DEPTH = {2'b01, {ADDR_W{1'b0}}};

  state_e              state, state_nxt;
  logic [1:0]          lat_cnt;
  logic [ADDR_W:0]     wp, rp, count;
  logic                full, empty, pop, flush, clr_ovf;
  logic                push_q, ovf, accept, ram_re_c;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W+1:0]   occ_nxt;
  logic [31:0]         status, rsp_data, prdata_q;
  logic                rsp_set, rsp_err, pready_q, pslverr_q, irq_q;
  logic [1:0]          idx;
  logic                setup;
  logic                unused_bits;

  fifo_ptr_ctrl #(.ADDR_W(ADDR_W)) u_ptr (
    .clk(clk), .resetn(resetn), .push(push_q), .pop(pop), .flush(flush),
    .wp(wp), .rp(rp), .count(count), .full(full), .empty(empty)
  );

  assign pop   = (state == RESP);
  assign idx   = paddr[3:2];
  assign setup = psel && !penable;

  // Occupancy seen by a new byte includes a write still in flight and a pop
  // retiring this cycle, so back-to-back strobes cannot overrun the RAM.
  assign occ_nxt = {1'b0, count} + (ADDR_W+2)'(push_q) - (ADDR_W+2)'(pop);
  assign accept  = rx_valid && (occ_nxt < DEPTH);

  always_comb begin
    status           = '0;
    status[31:16]    = 16'(count);
    status[ST_OVF]   = ovf;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
  end

  always_comb begin
    state_nxt = state;
    ram_re_c  = 1'b0;
    flush     = 1'b0;
    clr_ovf   = 1'b0;
    rsp_set   = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    unique case (state)
      IDLE: if (setup) begin
        rsp_set = 1'b1;
        unique case (idx)
          REG_DATA: begin
            if (pwrite || empty) rsp_err = 1'b1;
            else begin
              ram_re_c  = 1'b1;
              rsp_set   = 1'b0;
              state_nxt = RD_WAIT;
            end
          end
          REG_STATUS: if (!pwrite) rsp_data = status;
          REG_CTRL: if (pwrite) begin
            flush   = pwdata[CTRL_FLUSH];
            clr_ovf = pwdata[CTRL_CLR_OVF];
          end
          default: rsp_err = 1'b1;
        endcase
      end
      RD_WAIT: if (lat_cnt == 2'(RD_LAT-1)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      push_q    <= 1'b0;
      wdata_q   <= '0;
      ovf       <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= (state == RD_WAIT) ? lat_cnt + 2'd1 : 2'd0;
      if (rsp_set) begin
        pready_q  <= 1'b1;
        pslverr_q <= rsp_err;
        prdata_q  <= rsp_data;
      end else if (state == RD_WAIT && state_nxt == RESP) begin
        pready_q  <= 1'b1;
        pslverr_q <= 1'b0;
        prdata_q  <= 32'(ram_rdata[DATA_W-1:0]);
      end else begin
        pready_q  <= 1'b0;
        pslverr_q <= 1'b0;
        prdata_q  <= '0;
      end
      push_q <= accept;
      if (accept) wdata_q <= rx_data;
      if (rx_valid && !accept) ovf <= 1'b1;
      else if (clr_ovf)        ovf <= 1'b0;
      irq_q <= !empty;
    end
  end

  assign ram_we     = push_q;
  assign ram_waddr  = wp[ADDR_W-1:0];
  assign ram_wdata  = {1'b0, wdata_q};
  assign ram_raddr  = rp[ADDR_W-1:0];
  // read enable is combinational off the setup phase; hold it low in reset
  assign ram_re     = ram_re_c && resetn;
  assign prdata     = prdata_q;
  assign pready     = pready_q;
  assign pslverr    = pslverr_q;
  assign irq_nempty = irq_q;

  assign unused_bits = ^{paddr[15:4], paddr[1:0], pwdata[31:2], ram_rdata[DATA_W]};
endmodule

// File: tb/tb_apb_rxfifo_ctrl.sv
// Randomized bench for apb_rxfifo_ctrl against a queue-based FIFO model, with a
// behavioural synchronous RAM and a simple APB master.
module tb_apb_rxfifo_ctrl;
  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  ram_waddr, ram_raddr;
  logic [8:0]  ram_wdata, ram_rdata;
  logic        ram_we, ram_re;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, irq_nempty;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  logic       ovf_m;
  int         wr_idx, rd_idx;

  apb_rxfifo_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .irq_nempty(irq_nempty)
  );

  always #5 clk = ~clk;

  logic [8:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [1:0] idx, input logic [31:0] wd,
                     input logic inj, input logic [7:0] inj_d,
                     output logic [31:0] rd, output logic err, output int waits);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; pwdata = wd;
    paddr = {12'($urandom), idx, 2'($urandom)};
    @(posedge clk); #1;
    penable = 1'b1;
    if (inj) begin rx_valid = 1'b1; rx_data = inj_d; end
    waits = 0;
    while (pready !== 1'b1 && waits < 20) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
      waits++;
    end
    rd  = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    if (q.size() < 256) begin q.push_back(d); wr_idx++; end
    else ovf_m = 1'b1;
  endtask

  task automatic do_pop(input logic inj, input logic [7:0] inj_d);
    logic [31:0] rd; logic err; int w; logic was_empty; logic [7:0] e;
    was_empty = (q.size() == 0);
    apb(1'b0, 2'd0, 32'h0, inj, inj_d, rd, err, w);
    if (inj) begin
      if (q.size() < 256) begin q.push_back(inj_d); wr_idx++; end
      else ovf_m = 1'b1;
    end
    if (was_empty) begin
      chk("pop_empty_err", err, 1);
      chk("pop_empty_data", rd, 0);
      chk("pop_empty_wait", w, 0);
    end else begin
      e = q.pop_front();
      rd_idx++;
      chk("pop_data", rd, {24'h0, e});
      chk("pop_err", err, 0);
      chk("pop_wait", w, RD_LAT);
    end
  endtask

  task automatic do_status(input string tag);
    logic [31:0] rd, e; logic err; int w; int n;
    apb(1'b0, 2'd1, 32'h0, 1'b0, 8'h0, rd, err, w);
    n = q.size();
    e = (32'(n) << 16) | (32'(ovf_m) << 2) | (32'(n == 256) << 1) | 32'(n == 0);
    chk(tag, rd, e);
    chk("status_err", err, 0);
    chk("status_wait", w, 0);
    chk("waddr", ram_waddr, wr_idx & 255);
    chk("raddr", ram_raddr, rd_idx & 255);
    chk("irq", irq_nempty, n != 0);
  endtask

  task automatic do_ctrl(input logic [1:0] v);
    logic [31:0] rd; logic err; int w;
    apb(1'b1, 2'd2, {30'($urandom), v}, 1'b0, 8'h0, rd, err, w);
    if (v[0]) begin q.delete(); rd_idx = wr_idx; end
    if (v[1]) ovf_m = 1'b0;
    chk("ctrl_err", err, 0);
    chk("ctrl_wait", w, 0);
  endtask

  task automatic do_bad(input logic wr, input logic [1:0] idx);
    logic [31:0] rd; logic err; int w;
    apb(wr, idx, $urandom, 1'b0, 8'h0, rd, err, w);
    chk("bad_err", err, 1);
    chk("bad_wait", w, 0);
    if (!wr) chk("bad_rdata", rd, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; rx_valid = 1'b0; rx_data = '0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    ovf_m = 1'b0; wr_idx = 0; rd_idx = 0;
    #1;
    chk("rst_pready", pready, 0);
    chk("rst_pslverr", pslverr, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_re", ram_re, 0);
    chk("rst_irq", irq_nempty, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    do_status("t1_status");

    push(8'hA5);
    push(8'h3C);
    do_pop(1'b0, 8'h0);
    do_pop(1'b0, 8'h0);
    do_status("t2_status");

    do_pop(1'b0, 8'h0);
    do_status("t3_status");

    for (int i = 0; i < 257; i++) push(8'($urandom));
    do_status("t4_full_ovf");
    do_ctrl(2'b10);
    do_status("t4_ovf_clr");
    for (int i = 0; i < 256; i++) do_pop(1'b0, 8'h0);
    do_status("t4_drained");

    for (int i = 0; i < 5; i++) push(8'($urandom));
    for (int i = 0; i < 300; i++) begin
      do_pop(1'b1, 8'($urandom));
      if (i % 60 == 0) do_status("t5_count");
    end
    do_status("t5_after_wrap");

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: push(8'($urandom));
        4, 5:       do_pop((q.size() != 0) && ($urandom_range(0, 1) == 1), 8'($urandom));
        6:          do_status("rnd_status");
        7:          do_ctrl({1'b1, ($urandom_range(0, 3) == 0)});
        8:          do_bad($urandom_range(0, 1) == 1, 2'd3);
        default:    do_bad(1'b1, 2'd0);
      endcase
    end
    do_status("rnd_final");

    push(8'h77);
    push(8'h78);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0000;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("t6_pready", pready, 0);
    chk("t6_prdata", prdata, 0);
    chk("t6_waddr", ram_waddr, 0);
    chk("t6_raddr", ram_raddr, 0);
    chk("t6_irq", irq_nempty, 0);
    psel = 1'b0; penable = 1'b0;
    q.delete(); ovf_m = 1'b0; wr_idx = 0; rd_idx = 0;
    @(posedge clk); #1 resetn = 1'b1;
    do_status("t6_status");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
